// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU controller: instruction field codes,
// ALU function codes, branch condition codes, FSM state and write-back encodings,
// the decoded control word, and small decode helpers.
package cpu_pkg;

  // Major opcodes (IR[15:12]); immediate ALU forms reuse the ALU ext code as opcode.
  localparam logic [3:0] OpRegAlu = 4'b0000;
  localparam logic [3:0] OpLdSt   = 4'b0100;
  localparam logic [3:0] OpBcond  = 4'b1100;

  // ALU ext codes (IR[7:4] for register forms, IR[15:12] for immediate forms).
  localparam logic [3:0] ExtAnd = 4'b0001;
  localparam logic [3:0] ExtOr  = 4'b0010;
  localparam logic [3:0] ExtXor = 4'b0011;
  localparam logic [3:0] ExtAdd = 4'b0101;
  localparam logic [3:0] ExtSub = 4'b1001;
  localparam logic [3:0] ExtCmp = 4'b1011;
  localparam logic [3:0] ExtMov = 4'b1101;

  // Memory ext codes under OpLdSt.
  localparam logic [3:0] ExtLoad = 4'b0000;
  localparam logic [3:0] ExtStor = 4'b0100;

  // Branch conditions (Rdest field of a Bcond).
  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondLt = 4'b1100;
  localparam logic [3:0] CondAl = 4'b1110;

  typedef enum logic [3:0] {
    AluAdd = 4'd0,
    AluSub = 4'd1,
    AluAnd = 4'd2,
    AluOr  = 4'd3,
    AluXor = 4'd4,
    AluMov = 4'd5
  } alu_op_e;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMemwb  = 3'd3
  } state_e;

  typedef enum logic [1:0] {
    WbAlu = 2'b00,
    WbMem = 2'b01,
    WbImm = 2'b10
  } wb_sel_e;

  typedef struct packed {
    logic    rf_en;
    logic    mem_we;
    logic    mem_addr_sel;
    logic    flags_en;
    logic    alu_src_imm;
    wb_sel_e wb_sel;
    alu_op_e alu_op;
    logic    to_memwb;  // EXEC continues into MEMWB instead of retiring
    logic    br_taken;  // EXEC retires to pc + imm instead of pc + 1
  } ctrl_t;

  function automatic logic is_alu_code(logic [3:0] code);
    return code inside {ExtAnd, ExtOr, ExtXor, ExtAdd, ExtSub, ExtCmp, ExtMov};
  endfunction

  // CMP is a subtract whose result is discarded.
  function automatic alu_op_e alu_op_of(logic [3:0] code);
    case (code)
      ExtSub, ExtCmp: return AluSub;
      ExtAnd:         return AluAnd;
      ExtOr:          return AluOr;
      ExtXor:         return AluXor;
      ExtMov:         return AluMov;
      default:        return AluAdd;
    endcase
  endfunction

  // Unlisted condition codes are never taken.
  function automatic logic cond_met(logic [3:0] cond, logic z, logic n);
    case (cond)
      CondEq:  return z;
      CondNe:  return !z;
      CondLt:  return n;
      CondAl:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Controller-side bus of the CPU: memory/flag inputs to the controller and the
// register-file, ALU and memory control outputs it drives.
//  master: the controller (drives pc and all controls, reads mem_rdata and flags)
//  slave : the datapath/environment side
interface cpu_control_fsm_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [15:0]       mem_rdata;
  logic              flag_z;
  logic              flag_n;
  logic [ADDR_W-1:0] pc;
  logic              mem_addr_sel;
  logic              mem_we;
  logic              rf_en;
  logic [3:0]        rf_rw_addr;
  logic [3:0]        rf_rd_addr;
  logic [1:0]        wb_sel;
  logic [3:0]        alu_op;
  logic              alu_src_imm;
  logic [15:0]       imm;
  logic              flags_en;
  logic [2:0]        state;

  modport master (
    input  mem_rdata, flag_z, flag_n,
    output pc, mem_addr_sel, mem_we, rf_en, rf_rw_addr, rf_rd_addr, wb_sel, alu_op,
           alu_src_imm, imm, flags_en, state
  );

  modport slave (
    output mem_rdata, flag_z, flag_n,
    input  pc, mem_addr_sel, mem_we, rf_en, rf_rw_addr, rf_rd_addr, wb_sel, alu_op,
           alu_src_imm, imm, flags_en, state
  );
endinterface

// File: rtl/cpu_decode.sv
// Combinational instruction decoder: turns the current state and IR into the
// control word for this cycle. Strobes are only ever raised in EXEC/MEMWB.
//  state_i  : current controller state
//  ir_i     : instruction register
//  flag_z_i : zero flag, consulted only by branches in EXEC
//  flag_n_i : negative flag, consulted only by branches in EXEC
//  ctrl_o   : decoded control word
//  imm_o    : sign-extended IR[7:0]
module cpu_decode
  import cpu_pkg::*;
(
  input  state_e      state_i,
  input  logic [15:0] ir_i,
  input  logic        flag_z_i,
  input  logic        flag_n_i,
  output ctrl_t       ctrl_o,
  output logic [15:0] imm_o
);

  logic [3:0] op;
  logic [3:0] ext;
  logic [3:0] cond;
  logic [3:0] alu_code;
  logic       reg_alu;
  logic       imm_alu;

  assign op    = ir_i[15:12];
  assign cond  = ir_i[11:8];
  assign ext   = ir_i[7:4];
  assign imm_o = {{8{ir_i[7]}}, ir_i[7:0]};

  assign reg_alu  = (op == OpRegAlu) && is_alu_code(ext);
  assign imm_alu  = (op != OpRegAlu) && is_alu_code(op);
  assign alu_code = reg_alu ? ext : op;

  always_comb begin
    ctrl_o        = '0;
    ctrl_o.wb_sel = WbAlu;
    ctrl_o.alu_op = AluAdd;
    case (state_i)
      StExec: begin
        if (reg_alu || imm_alu) begin
          ctrl_o.rf_en       = (alu_code != ExtCmp);
          ctrl_o.flags_en    = alu_code inside {ExtAdd, ExtSub, ExtCmp};
          ctrl_o.alu_src_imm = imm_alu;
          ctrl_o.alu_op      = alu_op_of(alu_code);
          if (imm_alu && (alu_code == ExtMov)) ctrl_o.wb_sel = WbImm;
        end else if ((op == OpLdSt) && (ext == ExtLoad)) begin
          ctrl_o.mem_addr_sel = 1'b1;
          ctrl_o.to_memwb     = 1'b1;
        end else if ((op == OpLdSt) && (ext == ExtStor)) begin
          ctrl_o.mem_addr_sel = 1'b1;
          ctrl_o.mem_we       = 1'b1;
        end else if (op == OpBcond) begin
          ctrl_o.br_taken = cond_met(cond, flag_z_i, flag_n_i);
        end
        // Anything else falls through as a NOP and simply advances pc.
      end
      StMemwb: begin
        ctrl_o.rf_en  = 1'b1;
        ctrl_o.wb_sel = WbMem;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute controller. Holds state, pc and IR; all
// control outputs are decoded combinationally from state + IR by cpu_decode.
//  clk   : rising-edge clock
//  Reset : asynchronous active-high reset (state FETCH, pc RESET_PC, IR 0)
//  bus   : controller bus (master modport) carrying memory/flag inputs and
//          pc, register-file, ALU and memory controls
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                Reset,
  cpu_control_fsm_if.master  bus
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       ir_q;
  ctrl_t             ctrl;
  logic [15:0]       imm;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_br;

  cpu_decode u_decode (
    .state_i  (state_q),
    .ir_i     (ir_q),
    .flag_z_i (bus.flag_z),
    .flag_n_i (bus.flag_n),
    .ctrl_o   (ctrl),
    .imm_o    (imm)
  );

  // Both wrap modulo 2^ADDR_W.
  assign pc_inc = pc_q + ADDR_W'(1);
  assign pc_br  = pc_q + ADDR_W'($signed(imm));

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      case (state_q)
        StFetch: state_q <= StDecode;
        StDecode: begin
          ir_q    <= bus.mem_rdata;
          state_q <= StExec;
        end
        StExec: begin
          if (ctrl.to_memwb) begin
            state_q <= StMemwb;
          end else begin
            pc_q    <= ctrl.br_taken ? pc_br : pc_inc;
            state_q <= StFetch;
          end
        end
        StMemwb: begin
          pc_q    <= pc_inc;
          state_q <= StFetch;
        end
        default: state_q <= StFetch;
      endcase
    end
  end

  assign bus.pc           = pc_q;
  assign bus.state        = state_q;
  assign bus.mem_addr_sel = ctrl.mem_addr_sel;
  assign bus.mem_we       = ctrl.mem_we;
  assign bus.rf_en        = ctrl.rf_en;
  assign bus.flags_en     = ctrl.flags_en;
  assign bus.alu_src_imm  = ctrl.alu_src_imm;
  assign bus.wb_sel       = ctrl.wb_sel;
  assign bus.alu_op       = ctrl.alu_op;
  assign bus.rf_rw_addr   = ir_q[11:8];
  assign bus.rf_rd_addr   = ir_q[3:0];
  assign bus.imm          = imm;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: a driver presents instructions and flags
// at each FETCH and pushes the expected EXEC/MEMWB observations; a monitor pops
// and compares whenever the controller is in a strobe state.
module tb_cpu_control_fsm;
  import cpu_pkg::*;

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] pc;
    logic        rf_en;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        flags_en;
    logic        alu_src_imm;
    logic [1:0]  wb_sel;
    logic [3:0]  alu_op;
    logic        alu_care;
    logic [3:0]  rw;
    logic [3:0]  rd;
    logic [15:0] imm;
  } obs_t;

  logic clk = 1'b0;
  logic Reset;

  cpu_control_fsm_if #(.ADDR_W(16)) bus ();

  cpu_control_fsm #(
    .ADDR_W   (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  bit          sb_on  = 1'b0;
  obs_t        exp_q[$];
  logic [15:0] model_pc;
  logic [3:0]  alu_codes [7] = '{ExtAnd, ExtOr, ExtXor, ExtAdd, ExtSub, ExtCmp, ExtMov};
  logic [3:0]  conds [4]     = '{CondEq, CondNe, CondLt, CondAl};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  function automatic bit in_alu_set(logic [3:0] c);
    foreach (alu_codes[i]) if (alu_codes[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] alu_expect(logic [3:0] c);
    if (c == ExtAdd) return AluAdd;
    if (c == ExtSub || c == ExtCmp) return AluSub;
    if (c == ExtAnd) return AluAnd;
    if (c == ExtOr) return AluOr;
    if (c == ExtXor) return AluXor;
    return AluMov;
  endfunction

  // Reference behaviour of one instruction: expected observations and next pc.
  task automatic predict(input logic [15:0] instr, input logic z, input logic n);
    obs_t       e;
    logic [3:0] op;
    logic [3:0] ext;
    logic [3:0] code;
    bit         reg_alu;
    bit         imm_alu;
    bit         taken;
    int         next_pc;
    op      = instr[15:12];
    ext     = instr[7:4];
    e       = '0;
    e.st    = StExec;
    e.pc    = model_pc;
    e.rw    = instr[11:8];
    e.rd    = instr[3:0];
    e.imm   = {{8{instr[7]}}, instr[7:0]};
    next_pc = (int'(model_pc) + 1) % 65536;
    reg_alu = (op == 4'h0) && in_alu_set(ext);
    imm_alu = (op != 4'h0) && in_alu_set(op);
    if (reg_alu || imm_alu) begin
      code          = reg_alu ? ext : op;
      e.rf_en       = (code != ExtCmp);
      e.flags_en    = (code == ExtAdd) || (code == ExtSub) || (code == ExtCmp);
      e.alu_src_imm = imm_alu;
      e.wb_sel      = (imm_alu && code == ExtMov) ? 2'b10 : 2'b00;
      e.alu_op      = alu_expect(code);
      e.alu_care    = 1'b1;
      exp_q.push_back(e);
    end else if (op == 4'h4 && ext == 4'h0) begin
      e.mem_addr_sel = 1'b1;
      exp_q.push_back(e);
      e.st           = StMemwb;
      e.mem_addr_sel = 1'b0;
      e.rf_en        = 1'b1;
      e.wb_sel       = 2'b01;
      exp_q.push_back(e);
    end else if (op == 4'h4 && ext == 4'h4) begin
      e.mem_addr_sel = 1'b1;
      e.mem_we       = 1'b1;
      exp_q.push_back(e);
    end else if (op == 4'hC) begin
      case (instr[11:8])
        4'b0000: taken = z;
        4'b0001: taken = !z;
        4'b1100: taken = n;
        4'b1110: taken = 1'b1;
        default: taken = 1'b0;
      endcase
      if (taken) next_pc = (int'(model_pc) + int'($signed(instr[7:0]))) & 32'hFFFF;
      exp_q.push_back(e);
    end else begin
      exp_q.push_back(e);
    end
    model_pc = next_pc[15:0];
  endtask

  task automatic wait_for_fetch();
    for (int i = 0; i < 12; i++) begin
      if (bus.state == StFetch) return;
      @(negedge clk);
    end
    n_cmp++;
    n_fail++;
    $display("FAIL fetch_timeout: state %0d never returned to FETCH", bus.state);
    finish_run();
  endtask

  task automatic issue(input logic [15:0] instr, input logic z, input logic n);
    wait_for_fetch();
    bus.mem_rdata = instr;
    bus.flag_z    = z;
    bus.flag_n    = n;
    predict(instr, z, n);
    @(negedge clk);
  endtask

  // Monitor: strobe states pop the scoreboard, idle states must be quiet.
  always @(negedge clk) begin
    obs_t a;
    obs_t e;
    if (sb_on && !Reset) begin
      if (bus.state == StExec || bus.state == StMemwb) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_obs: state %0d pc %0h with nothing expected",
                   bus.state, bus.pc);
        end else begin
          e              = exp_q.pop_front();
          a.st           = bus.state;
          a.pc           = bus.pc;
          a.rf_en        = bus.rf_en;
          a.mem_we       = bus.mem_we;
          a.mem_addr_sel = bus.mem_addr_sel;
          a.flags_en     = bus.flags_en;
          a.alu_src_imm  = bus.alu_src_imm;
          a.wb_sel       = bus.wb_sel;
          a.alu_op       = e.alu_care ? bus.alu_op : e.alu_op;
          a.alu_care     = e.alu_care;
          a.rw           = bus.rf_rw_addr;
          a.rd           = bus.rf_rd_addr;
          a.imm          = bus.imm;
          check("exec_obs", 64'(a), 64'(e));
        end
      end else begin
        check("idle_strobes", 64'({bus.rf_en, bus.mem_we, bus.flags_en, bus.mem_addr_sel,
                                   bus.wb_sel}), 64'(0));
      end
    end
  end

  initial begin
    logic [15:0] instr;
    int unsigned k;
    Reset         = 1'b1;
    bus.mem_rdata = 16'h0000;
    bus.flag_z    = 1'b0;
    bus.flag_n    = 1'b0;
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    #1;
    check("reset_pc", 64'(bus.pc), 64'(16'h0000));
    check("reset_state", 64'(bus.state), 64'(StFetch));
    check("reset_strobes", 64'({bus.rf_en, bus.mem_we, bus.flags_en, bus.mem_addr_sel,
                                bus.wb_sel}), 64'(0));

    // Reset mid-EXEC must drop rf_en without waiting for a clock.
    bus.mem_rdata = 16'h0153;
    @(negedge clk);
    @(negedge clk);
    check("midreset_pre_state", 64'(bus.state), 64'(StExec));
    check("midreset_pre_rf_en", 64'(bus.rf_en), 64'(1));
    #2 Reset = 1'b1;
    #1;
    check("midreset_rf_en", 64'(bus.rf_en), 64'(0));
    check("midreset_state", 64'(bus.state), 64'(StFetch));
    check("midreset_pc", 64'(bus.pc), 64'(16'h0000));
    @(negedge clk);
    Reset    = 1'b0;
    model_pc = 16'h0000;
    sb_on    = 1'b1;

    issue(16'h0153, 1'b0, 1'b0);  // ADD R1,R3
    issue(16'h52FF, 1'b0, 1'b0);  // ADDI R2,-1
    issue(16'hD07F, 1'b0, 1'b0);  // MOVI R0,127
    issue(16'h4405, 1'b0, 1'b0);  // LOAD R4,[R5]
    issue(16'h4445, 1'b0, 1'b0);  // STOR
    issue(16'hF000, 1'b1, 1'b1);  // illegal -> NOP
    issue(16'h02B3, 1'b0, 1'b0);  // CMP R2,R3
    issue(16'hCE03, 1'b0, 1'b0);  // BAL +3 -> pc 10
    issue(16'hC0FE, 1'b1, 1'b0);  // BEQ -2 taken -> 8
    issue(16'hCE02, 1'b0, 1'b0);  // back to 10
    issue(16'hC0FE, 1'b0, 1'b0);  // BEQ not taken -> 11
    issue(16'hCEF4, 1'b0, 1'b0);  // -> 16'hFFFF
    issue(16'hC0FE, 1'b0, 1'b0);  // not taken, wraps to 0
    issue(16'hCE00, 1'b0, 1'b0);  // branch to self
    issue(16'hCE00, 1'b0, 1'b0);

    for (int i = 0; i < 100; i++) begin
      k = $urandom_range(0, 4);
      case (k)
        0: instr = {4'h0, 4'($urandom), alu_codes[$urandom_range(0, 6)], 4'($urandom)};
        1: instr = {alu_codes[$urandom_range(0, 6)], 4'($urandom), 8'($urandom)};
        2: instr = {4'h4, 4'($urandom), 4'h0, 4'($urandom)};
        3: instr = {4'h4, 4'($urandom), 4'h4, 4'($urandom)};
        default: instr = {4'hC, conds[$urandom_range(0, 3)], 8'($urandom)};
      endcase
      issue(instr, 1'($urandom), 1'($urandom));
    end

    wait_for_fetch();
    check("final_pc", 64'(bus.pc), 64'(model_pc));
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    finish_run();
  end

endmodule
